mdio_master_gen: RTL and testbench
==================================

MDIO_MASTER_GEN -- requirements
Module: mdio_master_gen

Interface
REQ-001 Parameter CLK_DIV, default 1, clk cycles per MDC half-period (legal 1..255).
REQ-002 Parameter PREAMBLE_LEN, default 32, MDC periods of preamble ones before ST (legal 0..32).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous and active-low.
REQ-005 MDIO_START  input  1  one-cycle request to launch a frame.
REQ-006 T_DATA  input  32  frame image: ST[31:30], OP[29:28], PHYAD/PRTAD[27:23], REGAD/DEVAD[22:18], TA[17:16], DATA[15:0].
REQ-007 MDIO_IN  input  1  serial data from the PHY.
REQ-008 MDC  output  1  management clock.
REQ-009 MDIO_OUT  output  1  serial data to the PHY.
REQ-010 MDIO_OE  output  1  output enable for the MDIO pad.
REQ-011 RD_DATA  output  16  last received read data.
REQ-012 DATA_RDY  output  1  one-cycle pulse: RD_DATA updated.
REQ-013 BUSY  output  1  frame in progress; new starts ignored.
REQ-014 ERR  output  1  one-cycle pulse: illegal ST/OP rejected.

Function
REQ-015 MDIO_START is accepted only in IDLE with BUSY=0; T_DATA is latched on acceptance and is not sampled again during the frame.
REQ-016 Legal codes are ST=01 with OP=01 (C22 write) or OP=10 (C22 read), and ST=00 with any OP (C45: 00 address, 01 write, 11 read, 10 post-read-increment read).
REQ-017 An illegal ST/OP pulses ERR for one cycle, sends no frame, leaves MDC idle, and keeps BUSY=0.
REQ-018 MDC idles low, toggles every CLK_DIV clk cycles while BUSY=1, and each bit period equals 2*CLK_DIV cycles.
REQ-019 MDIO_OUT and MDIO_OE change only in the cycle in which MDC is driven low; MDIO_IN is sampled in the cycle in which MDC is driven high.
REQ-020 The FSM states are IDLE -> PREAMBLE -> SHIFT_OUT -> (read only) TURNAROUND -> SHIFT_IN -> DONE -> IDLE; write and address frames go SHIFT_OUT -> DONE.
REQ-021 PREAMBLE drives MDIO_OUT=1 and MDIO_OE=1 for PREAMBLE_LEN bit periods; PREAMBLE_LEN=0 skips the state.
REQ-022 In write and address frames, SHIFT_OUT drives T_DATA[31] through T_DATA[0] MSB-first, with MDIO_OE=1.
REQ-023 In read frames, SHIFT_OUT drives T_DATA[31:18] only (14 bits); TURNAROUND then holds MDIO_OE=0 for 2 bit periods.
REQ-024 SHIFT_IN holds MDIO_OE=0 and shifts 16 MDIO_IN samples MSB-first into an internal register.
REQ-025 DONE lasts one cycle: for reads it loads RD_DATA and pulses DATA_RDY; it drives MDIO_OUT=0, MDIO_OE=0 and MDC=0; it clears BUSY on the following cycle.
REQ-026 RD_DATA holds its value until the next completed read; write, address and illegal requests do not alter it.
REQ-027 Frame length is (PREAMBLE_LEN+32)*2*CLK_DIV cycles from acceptance to DONE, for reads and writes alike.
REQ-028 The bit counter is 6 bits wide and never wraps; a start that coincides with DONE is ignored.

Reset
REQ-029 While reset=0 at posedge clk, the block sets MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=0, DATA_RDY=0, BUSY=0, ERR=0 and state=IDLE, including mid-frame.
REQ-030 After reset release, the first frame starts no earlier than the cycle after MDIO_START.

Structure
REQ-031 Shared package mdio_pkg holds the FSM state enum, the ST/OP code constants, and the field bit positions.
REQ-032 One sub-module, mdio_clkgen, generates MDC plus single-cycle mdc_rise/mdc_fall enables from CLK_DIV; all other logic lives in the top FSM.

Verification
REQ-033 C22 write, T_DATA=32'h508AA5A5, CLK_DIV=1 -> 32 ones, then 0101 0000 1000 1010 1010 0101 1010 0101; MDIO_OE=1 for 64 bit periods; BUSY high 128 cycles.
REQ-034 C22 read, T_DATA=32'h61840000, PHY model drives 16'hBEEF after TA -> MDIO_OE=0 for the last 18 bit periods; RD_DATA=16'hBEEF with a single-cycle DATA_RDY.
REQ-035 T_DATA=32'h70000000 (ST=01, OP=11) -> one ERR pulse; MDC stays 0; BUSY stays 0; RD_DATA unchanged.
REQ-036 C45 address, T_DATA=32'h00861234 -> all 32 bits driven after preamble; MDIO_OE=1 throughout; no DATA_RDY.
REQ-037 Second MDIO_START at bit 10 ignored, then reset=0 at bit 20 -> next cycle MDC=0, MDIO_OE=0, BUSY=0; a new frame after release completes normally.
REQ-038 CLK_DIV=4, PREAMBLE_LEN=0, write -> MDC period is 8 cycles; the frame lasts 256 cycles.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO master: FSM state encoding, ST/OP codes,
// frame field positions and the code-legality helpers used on acceptance.
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SHIFT_OUT,
      S_TURNAROUND,
      S_SHIFT_IN,
      S_DONE
   } mdio_state_t;

   // Start-of-frame codes
   localparam logic [1:0] ST_C45 = 2'b00;
   localparam logic [1:0] ST_C22 = 2'b01;

   // Opcodes
   localparam logic [1:0] OP_C22_WR    = 2'b01;
   localparam logic [1:0] OP_C22_RD    = 2'b10;
   localparam logic [1:0] OP_C45_ADDR  = 2'b00;
   localparam logic [1:0] OP_C45_WR    = 2'b01;
   localparam logic [1:0] OP_C45_RDINC = 2'b10;
   localparam logic [1:0] OP_C45_RD    = 2'b11;

   // Field LSB positions inside the 32-bit frame image
   localparam int ST_LSB    = 30;
   localparam int OP_LSB    = 28;
   localparam int PHYAD_LSB = 23;
   localparam int REGAD_LSB = 18;
   localparam int TA_LSB    = 16;

   // Bit-period counts derived from the field layout
   localparam int FRAME_BITS  = 32;
   localparam int RD_OUT_BITS = FRAME_BITS - REGAD_LSB;  // ST..REGAD
   localparam int TA_BITS     = REGAD_LSB - TA_LSB;
   localparam int RD_IN_BITS  = TA_LSB;

   function automatic logic code_legal(input logic [1:0] st, input logic [1:0] op);
      return (st == ST_C45) || ((st == ST_C22) && (op == OP_C22_WR || op == OP_C22_RD));
   endfunction

   // C45 reads are OP 10 and 11; C22 read is OP 10
   function automatic logic code_is_read(input logic [1:0] st, input logic [1:0] op);
      return ((st == ST_C45) && op[1]) || ((st == ST_C22) && (op == OP_C22_RD));
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator. While en=1, MDC toggles every CLK_DIV clk cycles; while en=0
// it is held low with the divider cleared, so the first high phase of a frame
// starts exactly CLK_DIV cycles after en rises.
//   clk, reset (sync, active-low), en  : inputs
//   mdc                                : management clock
//   mdc_rise / mdc_fall                : high in the cycle MDC is driven high / low
module mdio_clkgen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic mdc,
   output logic mdc_rise,
   output logic mdc_fall
);

   logic [7:0] cnt;
   logic       half_end;

   assign half_end = en && (cnt == 8'(CLK_DIV - 1));
   assign mdc_rise = half_end && !mdc;
   assign mdc_fall = half_end && mdc;

   always_ff @(posedge clk) begin
      if (!reset || !en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (half_end) begin
         cnt <= '0;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mdio_master_gen.sv
// MDIO (clause 22 / clause 45) management frame master.
// A frame is launched from a latched 32-bit image; reads shift out ST..REGAD,
// release the pad for turnaround and shift 16 bits in from the PHY.
//   clk, reset (sync, active-low)
//   MDIO_START, T_DATA[31:0], MDIO_IN        : request, frame image, PHY data
//   MDC, MDIO_OUT, MDIO_OE                   : serial interface
//   RD_DATA[15:0], DATA_RDY, BUSY, ERR       : status / read result
module mdio_master_gen
   import mdio_pkg::*;
#(
   parameter int CLK_DIV      = 1,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        BUSY,
   output logic        ERR
);

   mdio_state_t state, nxt;

   logic [5:0]  bit_cnt;
   logic [5:0]  state_len;
   logic [31:0] tx_sr;
   logic [15:0] rx_sr;
   logic        is_rd;
   logic        run;
   logic        accept;
   logic        legal;
   logic        last_bit;
   logic        mdc_rise, mdc_fall;

   assign legal  = code_legal(T_DATA[ST_LSB +: 2], T_DATA[OP_LSB +: 2]);
   // Only IDLE accepts; DONE therefore swallows a coincident start.
   assign accept = (state == S_IDLE) && MDIO_START;
   assign run    = (state == S_PREAMBLE) || (state == S_SHIFT_OUT) ||
                   (state == S_TURNAROUND) || (state == S_SHIFT_IN);

   mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk      (clk),
      .reset    (reset),
      .en       (run),
      .mdc      (MDC),
      .mdc_rise (mdc_rise),
      .mdc_fall (mdc_fall)
   );

   // Bit periods spent in the current state; a bit period ends on an MDC fall.
   always_comb begin
      state_len = 6'd1;
      case (state)
         S_PREAMBLE:   state_len = 6'(PREAMBLE_LEN);
         S_SHIFT_OUT:  state_len = is_rd ? 6'(RD_OUT_BITS) : 6'(FRAME_BITS);
         S_TURNAROUND: state_len = 6'(TA_BITS);
         S_SHIFT_IN:   state_len = 6'(RD_IN_BITS);
         default:      state_len = 6'd1;
      endcase
   end

   assign last_bit = mdc_fall && (bit_cnt == state_len - 6'd1);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= nxt;
   end

   // Next state
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:       if (accept && legal)
                          nxt = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_SHIFT_OUT;
         S_PREAMBLE:   if (last_bit) nxt = S_SHIFT_OUT;
         S_SHIFT_OUT:  if (last_bit) nxt = is_rd ? S_TURNAROUND : S_DONE;
         S_TURNAROUND: if (last_bit) nxt = S_SHIFT_IN;
         S_SHIFT_IN:   if (last_bit) nxt = S_DONE;
         S_DONE:       nxt = S_IDLE;
         default:      nxt = S_IDLE;
      endcase
   end

   // Outputs: pure functions of state and tx_sr, which only move on MDC falls
   // or on acceptance, so the pad only changes while MDC is being driven low.
   always_comb begin
      MDIO_OUT = 1'b0;
      MDIO_OE  = 1'b0;
      DATA_RDY = 1'b0;
      BUSY     = run;
      case (state)
         S_PREAMBLE:  begin MDIO_OUT = 1'b1;      MDIO_OE = 1'b1; end
         S_SHIFT_OUT: begin MDIO_OUT = tx_sr[31]; MDIO_OE = 1'b1; end
         S_DONE:      DATA_RDY = is_rd;
         default:     ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         is_rd   <= 1'b0;
         RD_DATA <= '0;
         ERR     <= 1'b0;
      end else begin
         ERR <= accept && !legal;
         if (accept && legal) begin
            tx_sr   <= T_DATA;
            is_rd   <= code_is_read(T_DATA[ST_LSB +: 2], T_DATA[OP_LSB +: 2]);
            bit_cnt <= '0;
         end else if (mdc_fall) begin
            bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
            if (state == S_SHIFT_OUT) tx_sr <= {tx_sr[30:0], 1'b0};
         end
         if (mdc_rise && state == S_SHIFT_IN) rx_sr <= {rx_sr[14:0], MDIO_IN};
         // Loaded on entry to DONE so RD_DATA is already valid while DATA_RDY is high.
         if (last_bit && state == S_SHIFT_IN) RD_DATA <= rx_sr;
      end
   end

endmodule

// File: tb/tb_mdio_master_gen.sv
module tb_mdio_master_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start    [2];
   logic [31:0] tdata    [2];
   logic [15:0] phy_word [2];
   logic        mdc [2], mout [2], moe [2], drdy [2], busy [2], err [2];
   logic [15:0] rdd [2];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic bit tb_legal(input logic [31:0] t);
      return (t[31:30] == 2'b00) || (t[31:30] == 2'b01 && (t[29:28] == 2'b01 || t[29:28] == 2'b10));
   endfunction

   function automatic bit tb_is_rd(input logic [31:0] t);
      return (t[31:30] == 2'b00) ? t[29] : (t[31:30] == 2'b01 && t[29:28] == 2'b10);
   endfunction

   // cfg[0]: CLK_DIV=1, PREAMBLE_LEN=32   cfg[1]: CLK_DIV=4, PREAMBLE_LEN=0
   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int D = (g == 0) ? 1 : 4;
      localparam int P = (g == 0) ? 32 : 0;
      localparam int L = (P + 32) * 2 * D;   // cycles from acceptance to DONE

      logic mdio_in;

      mdio_master_gen #(.CLK_DIV(D), .PREAMBLE_LEN(P)) dut (
         .clk        (clk),
         .reset      (reset),
         .MDIO_START (start[g]),
         .T_DATA     (tdata[g]),
         .MDIO_IN    (mdio_in),
         .MDC        (mdc[g]),
         .MDIO_OUT   (mout[g]),
         .MDIO_OE    (moe[g]),
         .RD_DATA    (rdd[g]),
         .DATA_RDY   (drdy[g]),
         .BUSY       (busy[g]),
         .ERR        (err[g])
      );

      // Model: a frame is just a cycle index s since acceptance; s==L is DONE.
      bit          act = 0, rd = 0, exp_err = 0, go = 0;
      int          s = 0;
      logic [31:0] t = '0;
      logic [15:0] pw = '0, exp_rd = '0;

      always @(posedge clk) begin
         go = 1;
         if (!reset) begin
            act = 0; s = 0; exp_rd = '0; exp_err = 0;
         end else begin
            exp_err = 0;
            if (act) begin
               s++;
               if (s == L && rd) exp_rd = pw;
               if (s > L) act = 0;
            end else if (start[g]) begin
               if (tb_legal(tdata[g])) begin
                  act = 1; s = 0; t = tdata[g]; rd = tb_is_rd(tdata[g]); pw = phy_word[g];
               end else exp_err = 1;
            end
         end
      end

      always @(negedge clk) begin
         int k, j;
         bit e_mdc, e_out, e_oe, e_busy, e_rdy, c_out;
         k = 0; e_mdc = 0; e_out = 0; e_oe = 0; e_busy = 0; e_rdy = 0; c_out = 0;
         if (act && s < L) begin
            k = s / (2 * D);
            e_mdc = (s % (2 * D)) >= D;
            e_busy = 1;
            if (k < P) begin e_out = 1; e_oe = 1; end
            else begin
               j = k - P;
               if (!rd || j < 14) begin e_out = t[31 - j]; e_oe = 1; end
            end
            c_out = e_oe;
         end else if (act) begin
            e_rdy = rd; c_out = 1;
         end
         if (go) begin
            chk($sformatf("cfg%0d mdc s=%0d", g, s), 64'(mdc[g]), 64'(e_mdc));
            chk($sformatf("cfg%0d oe s=%0d", g, s), 64'(moe[g]), 64'(e_oe));
            if (c_out) chk($sformatf("cfg%0d out s=%0d", g, s), 64'(mout[g]), 64'(e_out));
            chk($sformatf("cfg%0d busy s=%0d", g, s), 64'(busy[g]), 64'(e_busy));
            chk($sformatf("cfg%0d data_rdy s=%0d", g, s), 64'(drdy[g]), 64'(e_rdy));
            chk($sformatf("cfg%0d err", g), 64'(err[g]), 64'(exp_err));
            chk($sformatf("cfg%0d rd_data", g), 64'(rdd[g]), 64'(exp_rd));
         end
         // PHY: drive read data for the 16 trailing bit periods, noise elsewhere
         if (act && s < L && k >= P + 16) mdio_in = pw[15 - (k - P - 16)];
         else mdio_in = 1'($urandom_range(0, 1));
      end
   end

   task automatic frame(input int g, input logic [31:0] td, input logic [15:0] pw,
                        output int bcyc, output logic [63:0] cap, output int nrdy, output int per);
      int idle, r1, r2;
      bit prev;
      idle = 0; r1 = -1; r2 = -1; prev = 0;
      @(negedge clk); tdata[g] = td; phy_word[g] = pw; start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0; tdata[g] = $urandom;
      bcyc = 0; cap = '0; nrdy = 0;
      for (int i = 0; i < 3000 && idle < 4; i++) begin
         if (busy[g]) bcyc++; else if (bcyc > 0) idle++;
         if (mdc[g] && !prev) begin
            cap = {cap[62:0], mout[g]};
            if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
         end
         prev = mdc[g];
         if (drdy[g]) nrdy++;
         @(negedge clk);
      end
      per = r2 - r1;
      chk($sformatf("cfg%0d frame completes", g), 64'(idle >= 4), 64'd1);
   endtask

   task automatic illegal(input int g, input logic [31:0] td, output int nerr, output int nact);
      nerr = 0; nact = 0;
      @(negedge clk); tdata[g] = td; start[g] = 1'b1;
      @(negedge clk); start[g] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (err[g]) nerr++;
         if (busy[g] || mdc[g]) nact++;
         @(negedge clk);
      end
   endtask

   initial begin
      int bc, nr, pr, ne, na;
      logic [63:0] cp;
      logic [31:0] td;
      reset = 1'b0;
      for (int g = 0; g < 2; g++) begin start[g] = 0; tdata[g] = '0; phy_word[g] = '0; end
      repeat (3) @(negedge clk);
      chk("reset rd_data", 64'(rdd[0]), 64'h0);
      chk("reset busy", 64'(busy[0]), 64'h0);
      chk("reset oe", 64'(moe[1]), 64'h0);
      reset = 1'b1;
      @(negedge clk);

      // C22 write
      frame(0, 32'h508AA5A5, 16'h0, bc, cp, nr, pr);
      chk("c22 wr bits", cp, 64'hFFFFFFFF_508AA5A5);
      chk("c22 wr busy cycles", 64'(bc), 64'd128);
      chk("c22 wr mdc period", 64'(pr), 64'd2);
      chk("c22 wr no data_rdy", 64'(nr), 64'd0);

      // C22 read
      frame(0, 32'h61840000, 16'hBEEF, bc, cp, nr, pr);
      chk("c22 rd data", 64'(rdd[0]), 64'hBEEF);
      chk("c22 rd data_rdy pulses", 64'(nr), 64'd1);
      chk("c22 rd busy cycles", 64'(bc), 64'd128);

      // Illegal ST=01 OP=11
      illegal(0, 32'h70000000, ne, na);
      chk("illegal err pulses", 64'(ne), 64'd1);
      chk("illegal no activity", 64'(na), 64'd0);
      chk("illegal rd_data kept", 64'(rdd[0]), 64'hBEEF);

      // C45 address
      frame(0, 32'h00861234, 16'h0, bc, cp, nr, pr);
      chk("c45 addr bits", cp, 64'hFFFFFFFF_00861234);
      chk("c45 addr no data_rdy", 64'(nr), 64'd0);
      chk("c45 addr rd_data kept", 64'(rdd[0]), 64'hBEEF);

      // Ignored restart at bit 10, reset at bit 20
      @(negedge clk); tdata[0] = 32'h508AA5A5; start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (19) @(negedge clk);
      tdata[0] = 32'h61840000; start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mid reset mdc", 64'(mdc[0]), 64'h0);
      chk("mid reset oe", 64'(moe[0]), 64'h0);
      chk("mid reset busy", 64'(busy[0]), 64'h0);
      reset = 1'b1;
      frame(0, 32'h02A40000 | 32'h30000000, 16'h1357, bc, cp, nr, pr);
      chk("post reset c45 rd data", 64'(rdd[0]), 64'h1357);
      chk("post reset c45 rd data_rdy", 64'(nr), 64'd1);

      // CLK_DIV=4, no preamble
      frame(1, 32'h5F0F1234, 16'h0, bc, cp, nr, pr);
      chk("div4 wr bits", 64'(cp[31:0]), 64'h5F0F1234);
      chk("div4 wr busy cycles", 64'(bc), 64'd256);
      chk("div4 mdc period", 64'(pr), 64'd8);
      frame(1, 32'h6AAA0000, 16'hC3A5, bc, cp, nr, pr);
      chk("div4 rd data", 64'(rdd[1]), 64'hC3A5);

      // Randomized frames; the per-cycle model does the checking
      for (int n = 0; n < 14; n++) begin
         int g, kind;
         g = $urandom_range(0, 1);
         kind = $urandom_range(0, 3);
         td = $urandom;
         case (kind)
            0: td[31:30] = 2'b00;
            1: td[31:28] = 4'b0101;
            2: td[31:28] = 4'b0110;
            default: ;
         endcase
         if (tb_legal(td)) frame(g, td, 16'($urandom), bc, cp, nr, pr);
         else illegal(g, td, ne, na);
      end

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
